fir_filter_mac_seq: RTL and testbench

Parametrised successor to the fixed 4-tap FIR filter: an N-tap unsigned FIR with run-time programmable coefficients and a valid/ready input handshake. It uses one time-multiplexed multiply-accumulate unit instead of N parallel multipliers. It sits between the sample source and the downstream consumer and emits one full-precision result per accepted sample.

---
 rtl/fir_filter_mac_seq.sv | 140 ++++++++++++++
 tb/tb_fir_filter_mac_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_mac_seq.sv
// N-tap unsigned FIR with programmable coefficients and a single time-multiplexed MAC.
// Optional macro FIR_SYNC_CLEAR_EN adds a sync_clear input that zeroes the delay line and Data_out.
module fir_filter_mac_seq #(
   parameter int NUM_TAPS      = 4,
   parameter int WORD_SIZE_IN  = 4,
   parameter int COEF_SIZE     = 4,
   parameter int WORD_SIZE_OUT = WORD_SIZE_IN + COEF_SIZE + $clog2(NUM_TAPS),
   parameter int ADDR_W        = $clog2(NUM_TAPS)
) (
   input  logic                     clock,
   input  logic                     reset,
`ifdef FIR_SYNC_CLEAR_EN
   input  logic                     sync_clear,
`endif
   input  logic                     coef_wr_en,
   input  logic [ADDR_W-1:0]        coef_addr,
   input  logic [COEF_SIZE-1:0]     coef_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WORD_SIZE_IN-1:0]  Data_in,
   output logic                     out_valid,
   output logic [WORD_SIZE_OUT-1:0] Data_out,
   output logic                     busy
);

   localparam int PROD_W = WORD_SIZE_IN + COEF_SIZE;

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

   state_t                   r_state;
   state_t                   w_state_next;
   logic [WORD_SIZE_IN-1:0]  r_x [NUM_TAPS];
   logic [COEF_SIZE-1:0]     r_c [NUM_TAPS];
   logic [WORD_SIZE_OUT-1:0] r_acc;
   logic [WORD_SIZE_OUT-1:0] r_data_out;
   logic [ADDR_W-1:0]        r_k;
   logic                     r_out_valid;
   logic                     w_accept;
   logic                     w_coef_we;
   logic                     w_last_tap;
   logic                     w_clear;
   logic                     w_idle;
   logic [PROD_W-1:0]        w_prod;

   assign w_idle     = (r_state == S_IDLE);
   assign w_last_tap = (r_k == ADDR_W'(NUM_TAPS - 1));
   assign w_prod     = PROD_W'(r_x[r_k]) * PROD_W'(r_c[r_k]);
   assign w_coef_we  = coef_wr_en && w_idle && (int'(coef_addr) < NUM_TAPS);

`ifdef FIR_SYNC_CLEAR_EN
   // A clear requested while busy is remembered and applied on return to IDLE.
   logic r_clr_pend;
   assign w_clear  = w_idle && (sync_clear || r_clr_pend);
   assign in_ready = w_idle && !r_clr_pend;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_clr_pend <= 1'b0;
      end else if (w_idle) begin
         r_clr_pend <= 1'b0;
      end else if (sync_clear) begin
         r_clr_pend <= 1'b1;
      end
   end
`else
   assign w_clear  = 1'b0;
   assign in_ready = w_idle;
`endif

   assign busy      = !w_idle;
   assign out_valid = r_out_valid;
   assign Data_out  = r_data_out;

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid && !w_clear) begin
               w_accept     = 1'b1;
               w_state_next = S_MAC;
            end
         end
         S_MAC: begin
            if (w_last_tap) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_k         <= '0;
         r_data_out  <= '0;
         r_out_valid <= 1'b0;
         for (int i = 0; i < NUM_TAPS; i++) begin
            r_x[i] <= '0;
            r_c[i] <= COEF_SIZE'(1);
         end
      end else begin
         r_state     <= w_state_next;
         r_out_valid <= 1'b0;
         if (w_coef_we) begin
            r_c[coef_addr] <= coef_data;
         end
         case (r_state)
            S_IDLE: begin
               if (w_clear) begin
                  r_data_out <= '0;
                  for (int i = 0; i < NUM_TAPS; i++) begin
                     r_x[i] <= '0;
                  end
               end else if (w_accept) begin
                  r_x[0] <= Data_in;
                  for (int i = 1; i < NUM_TAPS; i++) begin
                     r_x[i] <= r_x[i-1];
                  end
                  r_acc <= '0;
                  r_k   <= '0;
               end
            end
            S_MAC: begin
               r_acc <= r_acc + WORD_SIZE_OUT'(w_prod);
               r_k   <= w_last_tap ? '0 : r_k + 1'b1;
            end
            S_DONE: begin
               r_data_out  <= r_acc;
               r_out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_filter_mac_seq.sv
// Scoreboard bench for fir_filter_mac_seq: the driver pushes model results, a monitor pops on out_valid.
module tb_fir_filter_mac_seq;

   localparam int NT = 4;
   localparam int WI = 4;
   localparam int CW = 4;
   localparam int AW = $clog2(NT);
   localparam int WO = WI + CW + $clog2(NT);

   logic          clock      = 1'b0;
   logic          reset      = 1'b0;
   logic          coef_wr_en = 1'b0;
   logic [AW-1:0] coef_addr  = '0;
   logic [CW-1:0] coef_data  = '0;
   logic          in_valid   = 1'b0;
   logic [WI-1:0] data_in    = '0;
   logic          in_ready;
   logic          out_valid;
   logic [WO-1:0] data_out;
   logic          busy;
`ifdef FIR_SYNC_CLEAR_EN
   logic          sync_clear = 1'b0;
`endif

   fir_filter_mac_seq #(.NUM_TAPS(NT), .WORD_SIZE_IN(WI), .COEF_SIZE(CW)) dut (
      .clock      (clock),
      .reset      (reset),
`ifdef FIR_SYNC_CLEAR_EN
      .sync_clear (sync_clear),
`endif
      .coef_wr_en (coef_wr_en),
      .coef_addr  (coef_addr),
      .coef_data  (coef_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .Data_in    (data_in),
      .out_valid  (out_valid),
      .Data_out   (data_out),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   typedef struct {int val; int cyc;} exp_t;

   int   mx [NT];
   int   mc [NT];
   exp_t sb [$];
   exp_t mon_e;
   int   cyc      = 0;
   int   n_chk    = 0;
   int   n_fail   = 0;
   int   last_out = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: y = sum over taps of c[k] * x[k], with x[0] the newest sample.
   function automatic int model_accept(int s);
      int sum = 0;
      for (int k = NT - 1; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = s;
      for (int k = 0; k < NT; k++) sum += mc[k] * mx[k];
      return sum;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NT; k++) begin
         mx[k] = 0;
         mc[k] = 1;
      end
      sb.delete();
      last_out = 0;
   endtask

   always @(negedge clock) begin
      if (reset && out_valid) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_out_valid: Data_out=%0d with no pending sample", data_out);
         end else begin
            mon_e = sb.pop_front();
            chk("data_out", int'(data_out), mon_e.val);
            chk("latency", cyc - mon_e.cyc, NT + 1);
            last_out = mon_e.val;
            $display("result Data_out=%0d expected=%0d latency=%0d", data_out, mon_e.val, cyc - mon_e.cyc);
         end
      end
   end

   task automatic send(int s, bit wc, int a, int d);
      int n = 0;
      @(negedge clock);
      in_valid = 1'b1;
      data_in  = WI'(s);
      if (wc) begin
         coef_wr_en = 1'b1;
         coef_addr  = AW'(a);
         coef_data  = CW'(d);
      end
      while (!in_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (n >= 50) begin
         chk("in_ready_timeout", 0, 1);
      end else begin
         exp_t e;
         if (wc) mc[a] = d;
         e.val = model_accept(s);
         e.cyc = cyc + 1;
         sb.push_back(e);
         $display("accept sample=%0d coef_write=%0d expected=%0d", s, wc, e.val);
      end
      @(negedge clock);
      in_valid   = 1'b0;
      coef_wr_en = 1'b0;
   endtask

   task automatic wr_coef(int a, int d, bit taken);
      @(negedge clock);
      coef_wr_en = 1'b1;
      coef_addr  = AW'(a);
      coef_data  = CW'(d);
      if (taken) mc[a] = d;
      $display("coef write addr=%0d data=%0d applied=%0d", a, d, taken);
      @(negedge clock);
      coef_wr_en = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) chk("idle_timeout", 0, 1);
      @(negedge clock);
      chk("data_out_hold", int'(data_out), last_out);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      #1;
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      #1;
      chk("rst_in_ready", int'(in_ready), 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int last_acc;
      int accs;
      model_reset();
      repeat (2) @(negedge clock);
      do_reset();

      // Default coefficients are all 1: running sum of the last four samples.
      send(6, 0, 0, 0); send(3, 0, 0, 0); send(2, 0, 0, 0); send(5, 0, 0, 0);
      wait_idle();

      // Coefficients survive only until reset.
      for (int a = 0; a < NT; a++) wr_coef(a, a + 1, 1);
      do_reset();
      for (int a = 0; a < NT; a++) wr_coef(a, a + 1, 1);
      send(2, 0, 0, 0); send(0, 0, 0, 0); send(2, 0, 0, 0); send(4, 0, 0, 0);
      wait_idle();

      // in_valid held high: one acceptance every NT+2 cycles.
      do_reset();
      @(negedge clock);
      in_valid = 1'b1;
      data_in  = WI'(1);
      last_acc = -1;
      accs     = 0;
      for (int i = 0; i < 40; i++) begin
         if (in_ready) begin
            exp_t e;
            e.val = model_accept(1);
            e.cyc = cyc + 1;
            sb.push_back(e);
            if (last_acc >= 0) chk("accept_gap", cyc - last_acc, NT + 2);
            last_acc = cyc;
            accs++;
            $display("accept sample=1 (streaming) expected=%0d", e.val);
         end
         @(negedge clock);
      end
      in_valid = 1'b0;
      chk("accept_count", accs, 7);
      wait_idle();

      // Coefficient write during MAC is ignored; in IDLE alongside a sample it applies.
      send(5, 0, 0, 0);
      wr_coef(0, 15, 0);
      wait_idle();
      send(3, 0, 0, 0);
      wait_idle();
      send(15, 1, 0, 15);
      wait_idle();

      // Reset in the second MAC cycle discards the sample.
      send(7, 0, 0, 0);
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_data_out", int'(data_out), 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (8) @(negedge clock);
      send(3, 0, 0, 0);
      wait_idle();

      // Full-scale coefficients and samples.
      do_reset();
      for (int a = 0; a < NT; a++) wr_coef(a, 15, 1);
      for (int i = 0; i < NT; i++) send(15, 0, 0, 0);
      wait_idle();
      chk("max_result", int'(data_out), 900);

      // Randomized samples, coefficient writes and idle gaps.
      for (int i = 0; i < 24; i++) begin
         int r = $urandom_range(0, 3);
         if (r == 0) begin
            wait_idle();
            wr_coef($urandom_range(0, NT - 1), $urandom_range(0, 15), 1);
         end
         repeat ($urandom_range(0, 3)) @(negedge clock);
         if (r == 1) begin
            wait_idle();
            send($urandom_range(0, 15), 1, $urandom_range(0, NT - 1), $urandom_range(0, 15));
         end else begin
            send($urandom_range(0, 15), 0, 0, 0);
         end
         if (r == 2) wr_coef($urandom_range(0, NT - 1), $urandom_range(0, 15), 0);
      end
      wait_idle();

`ifdef FIR_SYNC_CLEAR_EN
      // Clear in IDLE wins over a simultaneous sample.
      @(negedge clock);
      sync_clear = 1'b1;
      in_valid   = 1'b1;
      data_in    = WI'(9);
      @(negedge clock);
      sync_clear = 1'b0;
      in_valid   = 1'b0;
      for (int k = 0; k < NT; k++) mx[k] = 0;
      last_out = 0;
      chk("clr_in_ready", int'(in_ready), 1);
      chk("clr_busy", int'(busy), 0);
      chk("clr_data_out", int'(data_out), 0);
      send(1, 0, 0, 0);
      wait_idle();
      // Clear requested while busy: result still delivered, then cleared.
      send(5, 0, 0, 0);
      @(negedge clock);
      sync_clear = 1'b1;
      @(negedge clock);
      sync_clear = 1'b0;
      wait_idle();
      repeat (2) @(negedge clock);
      for (int k = 0; k < NT; k++) mx[k] = 0;
      last_out = 0;
      chk("pend_clr_data_out", int'(data_out), 0);
      send(2, 0, 0, 0);
      wait_idle();
`endif

      chk("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
